// File: rtl/mem_array_summer.sv
// Sums a run of 8-bit memory elements into a 16-bit accumulator and
// stores the result little-endian at dst/dst+1 through a single memory port.
module mem_array_summer #(
    parameter int ELEM_SIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic [7:0]  count,
    input  logic [7:0]  dst_addr,
    output logic [7:0]  mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_store,
    input  logic [7:0]  mem_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WRLO = 3'd2,
        WRHI = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_reg;
    logic [7:0]  ptr_reg;
    logic [7:0]  rem_reg;
    logic [7:0]  dst_reg;
    logic [15:0] acc_reg;
    logic [15:0] elem_ext;
    logic [15:0] acc_next;

    generate
        if (ELEM_SIGNED != 0) begin : g_sext
            assign elem_ext = {{8{mem_out[7]}}, mem_out};
        end else begin : g_zext
            assign elem_ext = {8'h00, mem_out};
        end
    endgenerate

    assign acc_next = acc_reg + elem_ext;

    // Outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= 8'h00;
            rem_reg     <= 8'h00;
            dst_reg     <= 8'h00;
            acc_reg     <= 16'h0000;
            mem_address <= 8'h00;
            mem_data    <= 8'h00;
            mem_store   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sum         <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        ptr_reg <= base_addr;
                        rem_reg <= count;
                        dst_reg <= dst_addr;
                        acc_reg <= 16'h0000;
                        busy    <= 1'b1;
                        if (count != 8'd0) begin
                            state_reg   <= READ;
                            mem_address <= base_addr;
                        end else begin
                            state_reg   <= WRLO;
                            mem_address <= dst_addr;
                            mem_data    <= 8'h00;
                            mem_store   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    acc_reg <= acc_next;
                    ptr_reg <= ptr_reg + 8'd1;
                    rem_reg <= rem_reg - 8'd1;
                    if (rem_reg == 8'd1) begin
                        state_reg   <= WRLO;
                        mem_address <= dst_reg;
                        mem_data    <= acc_next[7:0];
                        mem_store   <= 1'b1;
                    end else begin
                        mem_address <= ptr_reg + 8'd1;
                    end
                end
                WRLO: begin
                    state_reg   <= WRHI;
                    mem_address <= dst_reg + 8'd1;
                    mem_data    <= acc_reg[15:8];
                end
                WRHI: begin
                    state_reg   <= DONE;
                    mem_address <= 8'h00;
                    mem_data    <= 8'h00;
                    mem_store   <= 1'b0;
                    done        <= 1'b1;
                    sum         <= acc_reg;
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_address <= 8'h00;
                    mem_data    <= 8'h00;
                    mem_store   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_array_summer.sv
// Directed bench: signed and unsigned instances, each with its own behavioural memory.
module tb_mem_array_summer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr, count, dst_addr;
    logic [7:0]  mem_address, mem_data, mem_out;
    logic        mem_store, busy, done;
    logic [15:0] sum;
    logic [7:0]  mem_address_u, mem_data_u, mem_out_u;
    logic        mem_store_u, busy_u, done_u;
    logic [15:0] sum_u;

    logic [7:0] mem   [256];
    logic [7:0] mem_u [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_array_summer #(.ELEM_SIGNED(1)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .dst_addr(dst_addr), .mem_address(mem_address), .mem_data(mem_data),
        .mem_store(mem_store), .mem_out(mem_out), .busy(busy), .done(done), .sum(sum)
    );

    mem_array_summer #(.ELEM_SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .dst_addr(dst_addr), .mem_address(mem_address_u), .mem_data(mem_data_u),
        .mem_store(mem_store_u), .mem_out(mem_out_u), .busy(busy_u), .done(done_u), .sum(sum_u)
    );

    assign mem_out   = mem[mem_address];
    assign mem_out_u = mem_u[mem_address_u];

    always @(posedge clk) begin
        if (mem_store)   mem[mem_address]     <= mem_data;
        if (mem_store_u) mem_u[mem_address_u] <= mem_data_u;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        mem[a]   = v;
        mem_u[a] = v;
    endtask

    // Returns cycles from the start-sampling edge to the done cycle, or -1 on timeout.
    task automatic run_op(input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                          input bit poke_busy, output int lat);
        @(negedge clk);
        base_addr = b; count = c; dst_addr = d; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (poke_busy && lat == 1) begin
                start = 1'b1; base_addr = 8'd0; count = 8'd9; dst_addr = 8'd77;
            end
            if (poke_busy && lat == 2) start = 1'b0;
            if (done) break;
        end
        if (!done) lat = -1;
    endtask

    int lat;
    logic [7:0] vals [20];

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 8'd0; count = 8'd0; dst_addr = 8'd0;
        for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_store", mem_store, 0);
        check("rst_addr", mem_address, 0);
        check("rst_sum", sum, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Four small elements
        for (int i = 0; i < 4; i++) poke(8'(100 + i), 8'(i + 1));
        run_op(8'd100, 8'd4, 8'd200, 1'b0, lat);
        check("t1_lat", lat, 7);
        check("t1_busy", busy, 1);
        check("t1_sum", sum, 16'h000A);
        check("t1_m200", mem[200], 8'h0A);
        check("t1_m201", mem[201], 8'h00);

        // Twenty elements including a negative one
        vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10,
                 8'd11, 8'd15, 8'd14, 8'd13, 8'd12, 8'd10, 8'hF8, 8'd10, 8'd1, 8'd10};
        for (int i = 0; i < 20; i++) poke(8'(100 + i), vals[i]);
        run_op(8'd100, 8'd20, 8'd200, 1'b0, lat);
        check("t2_lat", lat, 23);
        check("t2_sum", sum, 16'h008F);
        check("t2_sum_u", sum_u, 16'h018F);
        check("t2_m200", mem[200], 8'h8F);
        check("t2_m201", mem[201], 8'h00);

        // Single negative element: sign versus zero extension
        run_op(8'd116, 8'd1, 8'd10, 1'b0, lat);
        check("t3_lat", lat, 4);
        check("t3_sum", sum, 16'hFFF8);
        check("t3_sum_u", sum_u, 16'h00F8);
        check("t3_m10", mem[10], 8'hF8);
        check("t3_m11", mem[11], 8'hFF);
        check("t3_m11_u", mem_u[11], 8'h00);

        // Zero-length run still writes a zero result
        poke(8'd50, 8'hAA); poke(8'd51, 8'hAA);
        run_op(8'd100, 8'd0, 8'd50, 1'b0, lat);
        check("t4_lat", lat, 3);
        check("t4_sum", sum, 16'h0000);
        check("t4_m50", mem[50], 8'h00);
        check("t4_m51", mem[51], 8'h00);

        // Address wrap with overlapping destination; extra start while busy
        poke(8'd255, 8'd5); poke(8'd0, 8'd7); poke(8'd77, 8'h33);
        run_op(8'd255, 8'd2, 8'd255, 1'b1, lat);
        check("t5_lat", lat, 5);
        check("t5_sum", sum, 16'h000C);
        check("t5_m255", mem[255], 8'h0C);
        check("t5_m0", mem[0], 8'h00);
        @(negedge clk);
        check("t5_idle_busy", busy, 0);
        @(negedge clk);
        check("t5_no_restart", busy, 0);
        check("t5_m77", mem[77], 8'h33);

        // Reset during WRHI aborts the write
        for (int i = 0; i < 4; i++) poke(8'(100 + i), 8'(i + 1));
        poke(8'd200, 8'h55); poke(8'd201, 8'h66);
        @(negedge clk);
        base_addr = 8'd100; count = 8'd4; dst_addr = 8'd200; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_store && mem_address == 8'd201) begin
                lat = i;
                break;
            end
        end
        check("t6_reach_wrhi", (lat >= 0) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        check("t6_store", mem_store, 0);
        check("t6_busy", busy, 0);
        check("t6_sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        check("t6_m200", mem[200], 8'h0A);
        check("t6_m201", mem[201], 8'h66);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) lat++;
        end
        check("t6_no_done", lat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_array_summer.md
MEM_ARRAY_SUMMER -- requirements
Module: mem_array_summer

Interface
REQ-001 The block SHALL have one parameter: ELEM_SIGNED, default 1; 1 sign-extends each element, 0 zero-extends it.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request pulse; sampled only in IDLE.
REQ-006 Port base_addr, input, 8 bits: address of the first element.
REQ-007 Port count, input, 8 bits: number of elements to sum, 0..255.
REQ-008 Port dst_addr, input, 8 bits: result destination; low byte at dst_addr, high byte at dst_addr+1.
REQ-009 Port mem_address, output, 8 bits: to the data memory address input.
REQ-010 Port mem_data, output, 8 bits: to the data memory write-data input.
REQ-011 Port mem_store, output, 1 bit: to the data memory write enable; the memory writes on the clk rising edge.
REQ-012 Port mem_out, input, 8 bits: combinational read data from the memory, valid in the same cycle as mem_address.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port done, output, 1 bit: one-cycle completion pulse.
REQ-015 Port sum, output, 16 bits: final accumulator value, held until the next accepted start.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, READ, WRLO, WRHI, DONE.
REQ-017 IDLE with start=1 SHALL latch ptr=base_addr, rem=count, dst=dst_addr and clear the accumulator to 0.
REQ-018 That same IDLE cycle SHALL go to READ if count!=0, else to WRLO.
REQ-019 READ SHALL drive mem_address=ptr and mem_store=0.
REQ-020 Each READ cycle SHALL update acc = acc + ext16(mem_out), ptr = ptr+1 mod 256, rem = rem-1.
REQ-021 READ SHALL go to WRLO when rem==1 on entry to the cycle; otherwise it stays in READ.
REQ-022 The accumulator SHALL be 16 bits with two's-complement wrap and no saturation.
REQ-023 ext16 SHALL sign-extend when ELEM_SIGNED=1 and zero-extend when ELEM_SIGNED=0.
REQ-024 WRLO SHALL drive mem_address=dst, mem_data=acc[7:0], mem_store=1, then go to WRHI.
REQ-025 WRHI SHALL drive mem_address=dst+1 mod 256, mem_data=acc[15:8], mem_store=1, then go to DONE.
REQ-026 DONE SHALL assert done=1 for that cycle, load sum=acc, and return to IDLE.
REQ-027 mem_store SHALL be 1 only in WRLO and WRHI.
REQ-028 In IDLE and DONE, mem_address SHALL be 0 and mem_data SHALL be 0.
REQ-029 Latency SHALL be: done asserted exactly max(count,0)+3 cycles after the start-sampling edge (count reads, WRLO, WRHI, DONE).
REQ-030 start SHALL be ignored while busy=1; no queuing.
REQ-031 base_addr, count and dst_addr changes after acceptance SHALL have no effect on the operation in progress.
REQ-032 Element addresses SHALL wrap from 255 to 0.
REQ-033 When the read range overlaps dst/dst+1, reads SHALL use pre-write memory contents, since all reads complete before WRLO.
REQ-034 start asserted in the DONE cycle SHALL be ignored; start is accepted on the following IDLE cycle.

Reset
REQ-035 rst=1 SHALL immediately, without waiting for clk, force state=IDLE.
REQ-036 rst=1 SHALL immediately force mem_store=0, mem_address=0, mem_data=0, busy=0, done=0, sum=0, acc=0, ptr=0, rem=0, dst=0.
REQ-037 Reset asserted mid-operation (including during WRLO or WRHI) SHALL abort the operation with no further memory write and no done pulse.

Verification
REQ-038 Memory preloaded mem[100..103]=1,2,3,4; start with base=100, count=4, dst=200 -> done 7 cycles later; sum=0x000A; mem[200]=0x0A, mem[201]=0x00.
REQ-039 Memory preloaded mem[100..119]=1..11,15,14,13,12,10,-8,10,1,10; base=100, count=20, dst=200 -> sum=0x008F (143); mem[200]=0x8F, mem[201]=0x00; done 23 cycles after start.
REQ-040 base=116 (value -8), count=1, dst=10 -> with ELEM_SIGNED=1, sum=0xFFF8 and mem[10]=0xF8, mem[11]=0xFF; with ELEM_SIGNED=0, sum=0x00F8.
REQ-041 count=0, dst=50 -> no read cycles; mem[50]=mem[51]=0; done 3 cycles after start.
REQ-042 Wrap case: mem[255]=5, mem[0]=7, base=255, count=2, dst=255 -> mem[255]=0x0C, mem[0]=0x00; second start asserted during busy is ignored.
REQ-043 Reset case: rst asserted in the cycle after WRLO is entered -> mem_store falls immediately, mem[dst+1] unchanged, done never pulses, busy=0.
